// File: rtl/nios_led_nios2_qsys_0_oci_dct_packer_pkg.sv
// Shared widths, state encoding and symbol placement helper for the DCT packer.
package nios_led_nios2_qsys_0_oci_dct_pkg;

    localparam int SYM_W = 3;
    localparam int SYMS  = 10;
    localparam int BUF_W = SYM_W * SYMS;
    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] SYMS_CNT = CNT_W'(SYMS);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } dct_state_e;

    // Position a symbol at slot 'slot' of an otherwise zero word.
    function automatic logic [BUF_W-1:0] place_sym(input logic [SYM_W-1:0] sym,
                                                   input logic [CNT_W-1:0] slot);
        place_sym = BUF_W'(sym) << (SYM_W * int'(slot));
    endfunction

endpackage

// File: rtl/nios_led_nios2_qsys_0_oci_dct_packer_if.sv
// Trace-symbol input, DCT word output and end-of-test handshake bundle.
interface nios_led_nios2_qsys_0_oci_dct_packer_if;
    import nios_led_nios2_qsys_0_oci_dct_pkg::*;

    logic             sym_valid;
    logic [SYM_W-1:0] sym_data;
    logic             sym_ready;
    logic             test_ending;
    logic             dct_valid;
    logic             dct_ready;
    logic [BUF_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;
    logic             test_has_ended;

    // Packer side.
    modport master (
        input  sym_valid, sym_data, test_ending, dct_ready,
        output sym_ready, dct_valid, dct_buffer, dct_count, test_has_ended
    );

    // Trace source / capture consumer side.
    modport slave (
        output sym_valid, sym_data, test_ending, dct_ready,
        input  sym_ready, dct_valid, dct_buffer, dct_count, test_has_ended
    );

endinterface

// File: rtl/nios_led_nios2_qsys_0_oci_dct_packer_slot.sv
// Output holding register: keeps a packed word stable until the consumer takes it.
module nios_led_nios2_qsys_0_oci_dct_slot
    import nios_led_nios2_qsys_0_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [BUF_W-1:0] i_buf,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [BUF_W-1:0] o_buf,
    output logic [CNT_W-1:0] o_cnt
);

    logic             r_valid;
    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;

    // Load a new word when the accumulator hands one over; drop valid once taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_buf   <= i_buf;
            r_cnt   <= i_cnt;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_buf   = r_buf;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/nios_led_nios2_qsys_0_oci_dct_packer.sv
// DCT packer: accumulates 3-bit trace symbols into 30-bit words and flushes on test end.
module nios_led_nios2_qsys_0_oci_dct_packer
    import nios_led_nios2_qsys_0_oci_dct_pkg::*;
(
    input  logic clk,
    input  logic reset,
    nios_led_nios2_qsys_0_oci_dct_packer_if.master bus
);

    dct_state_e       r_state;
    dct_state_e       w_state_nxt;
    logic [BUF_W-1:0] r_acc_buf;
    logic [BUF_W-1:0] w_acc_buf_nxt;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [CNT_W-1:0] w_acc_cnt_nxt;

    logic             w_slot_valid;
    logic [BUF_W-1:0] w_slot_buf;
    logic [CNT_W-1:0] w_slot_cnt;
    logic             w_slot_free;
    logic             w_acc_full;
    logic             w_acc_empty;
    logic             w_sym_ready;
    logic             w_accept;
    logic             w_xfer;

    assign w_acc_full  = (r_acc_cnt == SYMS_CNT);
    assign w_acc_empty = (r_acc_cnt == '0);
    assign w_slot_free = !w_slot_valid || bus.dct_ready;

    // A full accumulator can still accept because it empties into the slot this same cycle.
    assign w_sym_ready = (r_state == RUN) && (!w_acc_full || w_slot_free);
    assign w_accept    = bus.sym_valid && w_sym_ready;
    assign w_xfer      = w_slot_free && (r_state != DONE) &&
                         (w_acc_full || ((r_state == FLUSH) && !w_acc_empty));

    // Next-state: flush request, then wait for accumulator and slot to drain.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (bus.test_ending) w_state_nxt = FLUSH;
            FLUSH:   if (w_acc_empty && !w_slot_valid) w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_state_nxt;
    end

    // Accumulator next value: clear on handover, then place any accepted symbol.
    always_comb begin
        w_acc_buf_nxt = r_acc_buf;
        w_acc_cnt_nxt = r_acc_cnt;
        if (w_xfer) begin
            w_acc_buf_nxt = '0;
            w_acc_cnt_nxt = '0;
        end
        if (w_accept) begin
            w_acc_buf_nxt = w_acc_buf_nxt | place_sym(bus.sym_data, w_acc_cnt_nxt);
            w_acc_cnt_nxt = w_acc_cnt_nxt + CNT_W'(1);
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_buf <= '0;
            r_acc_cnt <= '0;
        end else begin
            r_acc_buf <= w_acc_buf_nxt;
            r_acc_cnt <= w_acc_cnt_nxt;
        end
    end

    nios_led_nios2_qsys_0_oci_dct_slot u_slot (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_xfer),
        .i_buf   (r_acc_buf),
        .i_cnt   (r_acc_cnt),
        .i_ready (bus.dct_ready),
        .o_valid (w_slot_valid),
        .o_buf   (w_slot_buf),
        .o_cnt   (w_slot_cnt)
    );

    assign bus.sym_ready      = w_sym_ready;
    assign bus.dct_valid      = w_slot_valid;
    assign bus.dct_buffer     = w_slot_buf;
    assign bus.dct_count      = w_slot_cnt;
    assign bus.test_has_ended = (r_state == DONE);

endmodule

// File: tb/tb_nios_led_nios2_qsys_0_oci_dct_packer.sv
// Bench for the DCT packer: queue-based reference model, stream scoreboard, directed + random stimulus.
module tb_nios_led_nios2_qsys_0_oci_dct_packer;
    import nios_led_nios2_qsys_0_oci_dct_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    nios_led_nios2_qsys_0_oci_dct_packer_if bus();

    nios_led_nios2_qsys_0_oci_dct_packer dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Word value = sum of symbol_k * 8^k.
    function automatic logic [BUF_W-1:0] pack_word(input int syms[$]);
        longint w  = 0;
        longint wt = 1;
        foreach (syms[k]) begin
            w  = w + longint'(syms[k]) * wt;
            wt = wt * 8;
        end
        return BUF_W'(w);
    endfunction

    // ---------------- reference model ----------------
    int               m_acc[$];
    bit               m_valid;
    logic [BUF_W-1:0] m_buf;
    int               m_cnt;
    int               m_phase;   // 0 running, 1 flushing, 2 ended
    bit               mv_free, mv_rdy, mv_acc, mv_xf, mv_was_empty, mv_was_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc.delete();
            m_valid = 1'b0;
            m_buf   = '0;
            m_cnt   = 0;
            m_phase = 0;
        end else begin
            mv_free      = !m_valid || bus.dct_ready;
            mv_rdy       = (m_phase == 0) && (m_acc.size() < SYMS || mv_free);
            mv_acc       = bus.sym_valid && mv_rdy;
            mv_xf        = (m_phase != 2) && mv_free &&
                           (m_acc.size() == SYMS || (m_phase == 1 && m_acc.size() != 0));
            mv_was_empty = (m_acc.size() == 0);
            mv_was_valid = m_valid;
            if (m_valid && bus.dct_ready) m_valid = 1'b0;
            if (mv_xf) begin
                m_buf   = pack_word(m_acc);
                m_cnt   = m_acc.size();
                m_valid = 1'b1;
                m_acc.delete();
            end
            if (mv_acc) m_acc.push_back(int'(bus.sym_data));
            if (m_phase == 0 && bus.test_ending) m_phase = 1;
            else if (m_phase == 1 && mv_was_empty && !mv_was_valid) m_phase = 2;
        end
    end

    // ---------------- per-cycle compare + scoreboard ----------------
    int               stream[$];
    logic [BUF_W-1:0] taken_bufs[$];
    int               taken_cnts[$];
    int               valid_cycles = 0;
    int               stall_cycles = 0;
    bit               mon_rdy;

    always @(negedge clk) begin
        mon_rdy = (m_phase == 0) && (m_acc.size() < SYMS || !m_valid || bus.dct_ready);
        chk("sym_ready", 64'(bus.sym_ready), 64'(mon_rdy));
        chk("dct_valid", 64'(bus.dct_valid), 64'(m_valid));
        chk("test_has_ended", 64'(bus.test_has_ended), 64'(m_phase == 2));
        if (m_valid) begin
            chk("dct_buffer", 64'(bus.dct_buffer), 64'(m_buf));
            chk("dct_count", 64'(bus.dct_count), 64'(m_cnt));
        end
        if (rst) begin
            stream.delete();
        end else begin
            if (bus.dct_valid && bus.dct_ready) begin
                taken_bufs.push_back(bus.dct_buffer);
                taken_cnts.push_back(int'(bus.dct_count));
                for (int k = 0; k < int'(bus.dct_count); k++) begin
                    if (stream.size() == 0) begin
                        chk("stream_underrun", 64'(k), 64'(SYMS + 1));
                    end else begin
                        chk("stream_sym", 64'((bus.dct_buffer >> (SYM_W * k)) & BUF_W'(7)),
                            64'(stream.pop_front()));
                    end
                end
            end
            if (bus.dct_valid) valid_cycles++;
            if (bus.sym_valid && !bus.sym_ready) stall_cycles++;
            if (bus.sym_valid && bus.sym_ready) stream.push_back(int'(bus.sym_data));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [SYM_W-1:0] s);
        int n = 0;
        bus.sym_valid = 1'b1;
        bus.sym_data  = s;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sym_ready && n < 200);
        if (!bus.sym_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accepted t=%0t", $time);
        end
        @(posedge clk);
        #1;
        bus.sym_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst             = 1'b1;
        bus.sym_valid   = 1'b0;
        bus.test_ending = 1'b0;
        bus.dct_ready   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse_end();
        bus.test_ending = 1'b1;
        @(posedge clk);
        #1;
        bus.test_ending = 1'b0;
    endtask

    task automatic wait_idle(input int n);
        repeat (n) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    int               w0, vc0, sc0;
    int               sent[$];
    int               sub[$];
    logic [SYM_W-1:0] sv;

    initial begin
        bus.sym_valid   = 1'b0;
        bus.sym_data    = '0;
        bus.test_ending = 1'b0;
        bus.dct_ready   = 1'b1;

        // reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_dct_valid", 64'(bus.dct_valid), 64'd0);
        chk("rst_dct_buffer", 64'(bus.dct_buffer), 64'd0);
        chk("rst_dct_count", 64'(bus.dct_count), 64'd0);
        chk("rst_sym_ready", 64'(bus.sym_ready), 64'd1);
        chk("rst_test_has_ended", 64'(bus.test_has_ended), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // symbols 0..7,0,1 -> one word, valid for one cycle
        w0  = taken_bufs.size();
        vc0 = valid_cycles;
        for (int i = 0; i < SYMS; i++) send(SYM_W'(i % 8));
        wait_idle(6);
        chk("t1_words", 64'(taken_bufs.size() - w0), 64'd1);
        if (taken_bufs.size() > w0) begin
            chk("t1_buffer", 64'(taken_bufs[w0]), 64'h08FA_C688);
            chk("t1_count", 64'(taken_cnts[w0]), 64'd10);
        end
        chk("t1_valid_cycles", 64'(valid_cycles - vc0), 64'd1);

        // 30 x symbol 5, sustained throughput
        w0  = taken_bufs.size();
        sc0 = stall_cycles;
        for (int i = 0; i < 3 * SYMS; i++) send(SYM_W'(5));
        wait_idle(6);
        chk("t2_words", 64'(taken_bufs.size() - w0), 64'd3);
        for (int i = w0; i < taken_bufs.size(); i++) begin
            chk("t2_buffer", 64'(taken_bufs[i]), 64'h2DB6_DB6D);
            chk("t2_count", 64'(taken_cnts[i]), 64'd10);
        end
        chk("t2_stalls", 64'(stall_cycles - sc0), 64'd0);

        // 4 x symbol 7 then flush
        do_reset();
        for (int i = 0; i < 4; i++) send(SYM_W'(7));
        pulse_end();
        @(negedge clk);
        chk("t3_valid_e0", 64'(bus.dct_valid), 64'd0);
        @(negedge clk);
        chk("t3_valid_e1", 64'(bus.dct_valid), 64'd1);
        chk("t3_buffer", 64'(bus.dct_buffer), 64'h0000_0FFF);
        chk("t3_count", 64'(bus.dct_count), 64'd4);
        chk("t3_ended_e1", 64'(bus.test_has_ended), 64'd0);
        @(negedge clk);
        chk("t3_valid_e2", 64'(bus.dct_valid), 64'd0);
        chk("t3_ended_e2", 64'(bus.test_has_ended), 64'd0);
        @(negedge clk);
        chk("t3_ended_e3", 64'(bus.test_has_ended), 64'd1);
        @(posedge clk);
        #1 bus.sym_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_ready_after_end", 64'(bus.sym_ready), 64'd0);
        end
        @(posedge clk);
        #1 bus.sym_valid = 1'b0;

        // back-pressure: 20 symbols with consumer stalled
        do_reset();
        bus.dct_ready = 1'b0;
        w0 = taken_bufs.size();
        sent.delete();
        for (int i = 0; i < 2 * SYMS; i++) begin
            sv = SYM_W'($urandom_range(0, 7));
            sent.push_back(int'(sv));
            send(sv);
        end
        sub = sent[0:SYMS-1];
        bus.sym_valid = 1'b1;
        bus.sym_data  = SYM_W'($urandom_range(0, 7));
        repeat (4) begin
            @(negedge clk);
            chk("t4_ready_low", 64'(bus.sym_ready), 64'd0);
            chk("t4_hold_buffer", 64'(bus.dct_buffer), 64'(pack_word(sub)));
        end
        @(posedge clk);
        #1 bus.dct_ready = 1'b1;
        @(negedge clk);
        chk("t4_resume_same_cycle", 64'(bus.sym_ready), 64'd1);
        @(posedge clk);
        #1 bus.sym_valid = 1'b0;
        wait_idle(6);
        chk("t4_words", 64'(taken_bufs.size() - w0), 64'd2);
        if (taken_bufs.size() >= w0 + 2) begin
            chk("t4_word0", 64'(taken_bufs[w0]), 64'(pack_word(sub)));
            sub = sent[SYMS:2*SYMS-1];
            chk("t4_word1", 64'(taken_bufs[w0+1]), 64'(pack_word(sub)));
        end

        // empty flush
        do_reset();
        w0 = taken_bufs.size();
        pulse_end();
        @(negedge clk);
        chk("t5_ended_e0", 64'(bus.test_has_ended), 64'd0);
        @(negedge clk);
        chk("t5_ended_e1", 64'(bus.test_has_ended), 64'd1);
        chk("t5_no_valid", 64'(bus.dct_valid), 64'd0);
        wait_idle(3);
        chk("t5_words", 64'(taken_bufs.size() - w0), 64'd0);

        // reset mid-word with a pending word
        do_reset();
        bus.dct_ready = 1'b0;
        for (int i = 0; i < SYMS + 6; i++) send(SYM_W'($urandom_range(0, 7)));
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(bus.dct_valid), 64'd0);
        chk("t6_rst_buffer", 64'(bus.dct_buffer), 64'd0);
        chk("t6_rst_count", 64'(bus.dct_count), 64'd0);
        chk("t6_rst_ready", 64'(bus.sym_ready), 64'd1);
        chk("t6_rst_ended", 64'(bus.test_has_ended), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.dct_ready = 1'b1;
        w0 = taken_bufs.size();
        sent.delete();
        for (int i = 0; i < SYMS; i++) begin
            sv = SYM_W'($urandom_range(0, 7));
            sent.push_back(int'(sv));
            send(sv);
        end
        wait_idle(6);
        chk("t6_words", 64'(taken_bufs.size() - w0), 64'd1);
        if (taken_bufs.size() > w0) begin
            chk("t6_buffer", 64'(taken_bufs[w0]), 64'(pack_word(sent)));
            chk("t6_count", 64'(taken_cnts[w0]), 64'd10);
        end

        // randomized traffic, flushes and resets; checked every cycle by the model
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc % 700 == 699) begin
                rst = 1'b1;
                bus.test_ending = 1'b0;
                bus.sym_valid   = 1'b0;
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                bus.sym_valid   = ($urandom_range(0, 3) != 0);
                bus.sym_data    = SYM_W'($urandom_range(0, 7));
                bus.dct_ready   = ($urandom_range(0, 2) != 0);
                bus.test_ending = ($urandom_range(0, 299) == 0);
            end
        end
        bus.sym_valid   = 1'b0;
        bus.test_ending = 1'b0;
        bus.dct_ready   = 1'b1;
        wait_idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
